// File: rtl/logic_clk_div_sched.sv
// Round-robin scheduler sharing one clock divider between two requesters: each burst
// loads D, then releases the divider reset for 2*N*D+1 cycles. Optional macro: CLK_DIV_SCHED_ABORT_EN.
module logic_clk_div_sched #(
    parameter int COUNTER_BITS = 32,
    parameter int BURST_BITS   = 16
) (
    input  logic                      i_master_clk,
    input  logic                      i_axi_reset,
    input  logic [1:0]                i_req_valid,
    output logic [1:0]                o_req_ready,
    input  logic [2*COUNTER_BITS-1:0] i_req_divider,
    input  logic [2*BURST_BITS-1:0]   i_req_cycles,
    output logic [1:0]                o_req_done,
    output logic [COUNTER_BITS-1:0]   o_div_cycles,
    output logic                      o_div_resetn,
    output logic                      o_grant_id,
    output logic                      o_busy,
    output logic                      o_err
`ifdef CLK_DIV_SCHED_ABORT_EN
    ,
    input  logic                      i_abort
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [COUNTER_BITS-1:0] ONE_D = 1;
    localparam logic [BURST_BITS:0]     ONE_H = 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [COUNTER_BITS-1:0] r_d;
    logic [BURST_BITS-1:0]   r_n;
    logic [COUNTER_BITS-1:0] r_div_cycles;
    logic                    r_grant;
    logic                    r_last_grant;
    logic                    r_err;
    logic [COUNTER_BITS-1:0] r_phase;
    logic [BURST_BITS:0]     r_half;
    logic                    r_lead;
    logic                    r_abort_pend;

    logic                    w_any;
    logic                    w_winner;
    logic                    w_accept;
    logic                    w_reject;
    logic [COUNTER_BITS-1:0] w_d_sel;
    logic [BURST_BITS-1:0]   w_n_sel;
    logic                    w_phase_wrap;
    logic                    w_half_last;
    logic                    w_stop_early;
    logic                    w_run_end;

    // Both valid: the requester not granted last time wins.
    assign w_any    = |i_req_valid;
    assign w_winner = (i_req_valid == 2'b11) ? ~r_last_grant : i_req_valid[1];
    assign w_accept = (r_state == S_IDLE) && w_any;
    assign w_d_sel  = w_winner ? i_req_divider[2*COUNTER_BITS-1:COUNTER_BITS]
                               : i_req_divider[COUNTER_BITS-1:0];
    assign w_n_sel  = w_winner ? i_req_cycles[2*BURST_BITS-1:BURST_BITS]
                               : i_req_cycles[BURST_BITS-1:0];
    assign w_reject = (w_d_sel == '0) || (w_n_sel == '0);

    assign w_phase_wrap = (r_phase == r_d - ONE_D);
    assign w_half_last  = (r_half == {r_n, 1'b0} - ONE_H);

`ifdef CLK_DIV_SCHED_ABORT_EN
    // Stop only after an odd half-period completes, so the divided clock is low.
    assign w_stop_early = (r_abort_pend || i_abort) && r_half[0];
`else
    assign w_stop_early = 1'b0;
`endif

    assign w_run_end = !r_lead && w_phase_wrap && (w_half_last || w_stop_early);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_reject ? S_DONE : S_LOAD;
            S_LOAD: w_state_next = S_RUN;
            S_RUN:  if (w_run_end) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_master_clk or posedge i_axi_reset) begin
        if (i_axi_reset) begin
            r_state      <= S_IDLE;
            r_d          <= '0;
            r_n          <= '0;
            r_div_cycles <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_err        <= 1'b0;
            r_phase      <= '0;
            r_half       <= '0;
            r_lead       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_d          <= w_d_sel;
                        r_n          <= w_n_sel;
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_err        <= w_reject;
                    end
                end
                S_LOAD: begin
                    r_div_cycles <= r_d;
                    r_phase      <= '0;
                    r_half       <= '0;
                    r_lead       <= 1'b1;
                    r_abort_pend <= 1'b0;
                end
                S_RUN: begin
                    // Lead cycle first, then D phases per half-period for 2N halves.
                    if (r_lead) begin
                        r_lead <= 1'b0;
                    end else if (w_phase_wrap) begin
                        r_phase <= '0;
                        r_half  <= r_half + ONE_H;
                    end else begin
                        r_phase <= r_phase + ONE_D;
                    end
`ifdef CLK_DIV_SCHED_ABORT_EN
                    if (i_abort) r_abort_pend <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready  = w_accept ? {w_winner, ~w_winner} : 2'b00;
    assign o_req_done   = (r_state == S_DONE) ? {r_grant, ~r_grant} : 2'b00;
    assign o_div_cycles = r_div_cycles;
    assign o_div_resetn = (r_state == S_RUN);
    assign o_grant_id   = r_grant;
    assign o_busy       = (r_state != S_IDLE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_logic_clk_div_sched.sv
// Scoreboard bench for logic_clk_div_sched with a behavioural divider model on its outputs.
module tb_logic_clk_div_sched;
    localparam int CB = 32;
    localparam int BB = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      valid = 2'b00;
    logic [1:0]      ready;
    logic [2*CB-1:0] divider = '0;
    logic [2*BB-1:0] cycles = '0;
    logic [1:0]      done;
    logic [CB-1:0]   div_cycles;
    logic            div_resetn;
    logic            grant_id;
    logic            busy;
    logic            err;
    logic            abort = 1'b0;

    always #5 clk = ~clk;

    logic_clk_div_sched #(.COUNTER_BITS(CB), .BURST_BITS(BB)) dut (
        .i_master_clk (clk),
        .i_axi_reset  (rst),
        .i_req_valid  (valid),
        .o_req_ready  (ready),
        .i_req_divider(divider),
        .i_req_cycles (cycles),
        .o_req_done   (done),
        .o_div_cycles (div_cycles),
        .o_div_resetn (div_resetn),
        .o_grant_id   (grant_id),
        .o_busy       (busy),
        .o_err        (err)
`ifdef CLK_DIV_SCHED_ABORT_EN
        ,
        .i_abort      (abort)
`endif
    );

    // Divider model: toggles every D enabled cycles, held low in reset.
    logic [CB-1:0] m_cnt;
    logic          m_clk;
    always @(posedge clk or negedge div_resetn) begin
        if (!div_resetn) begin
            m_cnt <= '0;
            m_clk <= 1'b0;
        end else if (m_cnt == div_cycles - 1) begin
            m_cnt <= '0;
            m_clk <= ~m_clk;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        int id;
        bit err;
        int lat;
        int rn_hi;
        int rises;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic accept_req(input int id, input logic [CB-1:0] d, input logic [BB-1:0] n,
                              output bit ok, output int waited);
        divider[id*CB +: CB] = d;
        cycles[id*BB +: BB]  = n;
        valid[id] = 1'b1;
        ok = 1'b0;
        waited = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ready[id]) begin
                ok = 1'b1;
                waited = k;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1 valid[id] = 1'b0;
        end
        $display("[TB] accept req%0d D=%0d N=%0d ok=%0d waited=%0d", id, d, n, ok, waited);
    endtask

    task automatic wait_done(input int abort_at, output int lat, output int rn_hi,
                             output int rises, output int got_id, output bit got_err,
                             output bit seen);
        logic prev;
        lat = 0; rn_hi = 0; rises = 0; got_id = -1; got_err = 1'b0; seen = 1'b0;
        prev = m_clk;
        for (int k = 0; k < 30000; k++) begin
            @(negedge clk);
            if (div_resetn) rn_hi++;
            abort = (abort_at != 0) && div_resetn && (rn_hi == abort_at);
            if (m_clk && !prev) rises++;
            prev = m_clk;
            if (done != 2'b00) begin
                lat = k + 1;
                got_id = done[1] ? 1 : 0;
                got_err = err;
                seen = 1'b1;
                break;
            end
        end
        abort = 1'b0;
        $display("[TB] done seen=%0d id=%0d lat=%0d resetn_hi=%0d rises=%0d err=%0d",
                 seen, got_id, lat, rn_hi, rises, got_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (div_resetn !== 1'b0 || div_cycles !== '0 || ready !== 2'b00 || done !== 2'b00 ||
            grant_id !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: resetn=%b cyc=%0d ready=%b done=%b grant=%b busy=%b err=%b",
                     div_resetn, div_cycles, ready, done, grant_id, busy, err);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_back_to_back();
        bit ok, e_err, seen; int w, lat, rn, ri, id; exp_t e;
        divider = {32'd2, 32'd2};
        cycles  = {16'd1, 16'd1};
        valid   = 2'b11;
        accept_req(0, 32'd2, 16'd1, ok, w);
        n_tests++;
        if (!ok || grant_id !== 1'b0) begin
            n_fail++; $display("FAIL first_grant: ok=%0d grant=%b want 0", ok, grant_id);
        end
        sb.push_back('{id:0, err:1'b0, lat:7, rn_hi:5, rises:1});
        wait_done(0, lat, rn, ri, id, e_err, seen);
        e = sb.pop_front();
        n_tests++;
        if (!seen || id != e.id || lat != e.lat || rn != e.rn_hi || ri != e.rises) begin
            n_fail++; $display("FAIL b2b_first_done: id=%0d lat=%0d rn=%0d rises=%0d want %0d/%0d/%0d/%0d",
                               id, lat, rn, ri, e.id, e.lat, e.rn_hi, e.rises);
        end
        accept_req(1, 32'd2, 16'd1, ok, w);
        n_tests++;
        if (!ok || w != 1 || grant_id !== 1'b1) begin
            n_fail++; $display("FAIL second_grant: ok=%0d waited=%0d grant=%b want 1/1", ok, w, grant_id);
        end
        sb.push_back('{id:1, err:1'b0, lat:7, rn_hi:5, rises:1});
        wait_done(0, lat, rn, ri, id, e_err, seen);
        e = sb.pop_front();
        n_tests++;
        if (!seen || id != e.id || lat != e.lat || rn != e.rn_hi || ri != e.rises) begin
            n_fail++; $display("FAIL b2b_second_done: id=%0d lat=%0d rn=%0d rises=%0d want %0d/%0d/%0d/%0d",
                               id, lat, rn, ri, e.id, e.lat, e.rn_hi, e.rises);
        end
    endtask

    task automatic test_burst(input int rid, input int d, input int n, input int abort_at,
                              input int exp_rn);
        bit ok, e_err, seen; int w, lat, rn, ri, id; exp_t e;
        accept_req(rid, d[CB-1:0], n[BB-1:0], ok, w);
        n_tests++;
        if (!ok || busy !== 1'b1 || grant_id !== rid[0]) begin
            n_fail++; $display("FAIL burst_accept: ok=%0d busy=%b grant=%b want 1/%0d", ok, busy, grant_id, rid);
        end
        sb.push_back('{id:rid, err:1'b0, lat:exp_rn + 2, rn_hi:exp_rn, rises:(exp_rn - 1) / (2 * d)});
        wait_done(abort_at, lat, rn, ri, id, e_err, seen);
        e = sb.pop_front();
        n_tests++;
        if (!seen || id != e.id || e_err != e.err || lat != e.lat || rn != e.rn_hi || ri != e.rises) begin
            n_fail++; $display("FAIL burst_D%0d_N%0d: id=%0d err=%0d lat=%0d rn=%0d rises=%0d want %0d/%0d/%0d/%0d/%0d",
                               d, n, id, e_err, lat, rn, ri, e.id, e.err, e.lat, e.rn_hi, e.rises);
        end
        n_tests++;
        if (div_cycles !== d[CB-1:0] || m_clk !== 1'b0) begin
            n_fail++; $display("FAIL burst_end_state: div_cycles=%0d m_clk=%b want %0d/0", div_cycles, m_clk, d);
        end
    endtask

    task automatic test_reject();
        bit ok, e_err, seen; int w, lat, rn, ri, id; exp_t e;
        accept_req(1, 32'd0, 16'd5, ok, w);
        sb.push_back('{id:1, err:1'b1, lat:1, rn_hi:0, rises:0});
        wait_done(0, lat, rn, ri, id, e_err, seen);
        e = sb.pop_front();
        n_tests++;
        if (!ok || !seen || id != e.id || e_err != e.err || lat != e.lat || rn != e.rn_hi) begin
            n_fail++; $display("FAIL reject: ok=%0d id=%0d err=%0d lat=%0d rn=%0d want %0d/%0d/%0d/%0d",
                               ok, id, e_err, lat, rn, e.id, e.err, e.lat, e.rn_hi);
        end
        accept_req(0, 32'd1, 16'd1, ok, w);
        n_tests++;
        if (!ok || err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: ok=%0d err=%b want 0", ok, err);
        end
        sb.push_back('{id:0, err:1'b0, lat:5, rn_hi:3, rises:1});
        wait_done(0, lat, rn, ri, id, e_err, seen);
        e = sb.pop_front();
        n_tests++;
        if (!seen || id != e.id || lat != e.lat || rn != e.rn_hi || ri != e.rises) begin
            n_fail++; $display("FAIL after_reject_done: id=%0d lat=%0d rn=%0d rises=%0d want %0d/%0d/%0d/%0d",
                               id, lat, rn, ri, e.id, e.lat, e.rn_hi, e.rises);
        end
    endtask

    task automatic test_mid_reset();
        bit ok; int w; int rn; bit any_done;
        accept_req(1, 32'd4, 16'd2, ok, w);
        rn = 0;
        for (int k = 0; k < 40 && rn < 5; k++) begin
            @(negedge clk);
            if (div_resetn) rn++;
        end
        n_tests++;
        if (!ok || rn != 5) begin
            n_fail++; $display("FAIL mid_reset_reach: ok=%0d run_cycles=%0d want 5", ok, rn);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (div_resetn !== 1'b0 || busy !== 1'b0 || ready !== 2'b00 || done !== 2'b00 ||
            grant_id !== 1'b0 || err !== 1'b0 || div_cycles !== '0 || m_clk !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: resetn=%b busy=%b ready=%b done=%b grant=%b err=%b cyc=%0d mclk=%b",
                               div_resetn, busy, ready, done, grant_id, err, div_cycles, m_clk);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done != 2'b00 || div_resetn) any_done = 1'b1;
        end
        n_tests++;
        if (any_done) begin
            n_fail++; $display("FAIL mid_reset_no_done: activity=%0d want 0", any_done);
        end
        $display("[TB] mid-burst reset checked");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_burst(0, 2, 3, 0, 13);
        test_reject();
        test_mid_reset();
        test_burst(0, 1, 1, 0, 3);
        test_burst(1, 1000, 5, 0, 10001);
`ifdef CLK_DIV_SCHED_ABORT_EN
        test_burst(0, 3, 10, 8, 13);
`endif
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_empty: left=%0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
